drive_sequencer: RTL and testbench

Command-driven maneuver controller sitting between the navigation logic and the H-bridge pins. It accepts timed or continuous drive commands over a valid/ready handshake and maps each opcode to per-side direction and speed. It gates the shared full-speed and veer-speed PWM streams onto the bridge enables. It enforces coast dead-time on every stop or direction reversal and latches an emergency stop on collision.

---
 rtl/drive_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_drive_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_sequencer.sv
// Command-driven H-bridge maneuver sequencer: opcode-to-bridge mapping, coast dead-time, latched collision fault.
// Optional continuous-mode watchdog is built when DRIVE_SEQ_WATCHDOG_EN is defined.
module drive_sequencer #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 1000,
  parameter int DEAD_TIME_TICKS = 20,
  parameter int WATCHDOG_TICKS  = 500
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic [2:0]  cmdOp,
  input  logic [11:0] cmdTicks,
  input  logic        collision,
  input  logic        clearFault,
  input  logic        pwmFull,
  input  logic        pwmVeer,
  output logic        hbEnA,
  output logic        hbEnB,
  output logic        hbIn1,
  output logic        hbIn2,
  output logic        hbIn3,
  output logic        hbIn4,
  output logic        busy,
  output logic        fault
);
  localparam int TICK_CYCLES = CLK_HZ / TICK_HZ;
  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [11:0]   DEAD_LOAD  = 12'(DEAD_TIME_TICKS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DEAD  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_FWD  = 2'b01;
  localparam logic [1:0] DIR_REV  = 2'b10;

  localparam logic [2:0] OP_VEER_L = 3'd3;
  localparam logic [2:0] OP_VEER_R = 3'd4;

  if (TICK_CYCLES < 2 || DEAD_TIME_TICKS < 1 || WATCHDOG_TICKS < 1) begin : g_param_check
    $error("drive_sequencer: invalid timing parameters");
  end

  // Returns {side A direction, side B direction}; STOP and the reserved opcode map to NONE.
  function automatic logic [3:0] op_dirs(input logic [2:0] op);
    case (op)
      3'd1:    op_dirs = {DIR_FWD, DIR_FWD};
      3'd2:    op_dirs = {DIR_REV, DIR_REV};
      3'd3:    op_dirs = {DIR_FWD, DIR_FWD};
      3'd4:    op_dirs = {DIR_FWD, DIR_FWD};
      3'd5:    op_dirs = {DIR_REV, DIR_FWD};
      3'd6:    op_dirs = {DIR_FWD, DIR_REV};
      default: op_dirs = {DIR_NONE, DIR_NONE};
    endcase
  endfunction

  logic [1:0]    r_state, w_state_nxt;
  logic [2:0]    r_op, r_pend_op, w_run_op;
  logic [11:0]   r_ticks, r_pend_ticks, w_run_ticks;
  logic          r_cont, r_pend_valid, w_set_pend;
  logic [1:0]    r_last_a, r_last_b;
  logic [PW-1:0] r_presc;
  logic          r_en_a, r_en_b;
  logic [1:0]    w_new_a, w_new_b, w_cur_a, w_cur_b, w_run_a, w_run_b;
  logic          w_accept, w_tick_end, w_cnt_done, w_go_run, w_go_dead;
  logic          w_new_stop, w_reverse, w_driving;

`ifdef DRIVE_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WATCHDOG_TICKS + 1);
  localparam logic [WW-1:0] WD_LOAD = WW'(WATCHDOG_TICKS);
  logic [WW-1:0] r_wd;
`endif

  assign {w_new_a, w_new_b} = op_dirs(cmdOp);
  assign {w_cur_a, w_cur_b} = op_dirs(r_op);
  assign {w_run_a, w_run_b} = op_dirs(w_run_op);

  assign cmdReady   = (r_state == S_IDLE) || (r_state == S_RUN && r_cont);
  assign w_accept   = cmdValid && cmdReady;
  assign w_new_stop = (w_new_a == DIR_NONE);
  // FWD and REV are one-hot, so OR-ing new and last direction gives 2'b11 only on a reversal.
  assign w_reverse  = ((w_new_a | r_last_a) == 2'b11) || ((w_new_b | r_last_b) == 2'b11);
  assign w_tick_end = (r_presc == PRESC_LAST);
  assign w_cnt_done = w_tick_end && (r_ticks == 12'd1);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    w_state_nxt = r_state;
    w_go_run    = 1'b0;
    w_go_dead   = 1'b0;
    w_set_pend  = 1'b0;
    w_run_op    = cmdOp;
    w_run_ticks = cmdTicks;
    if (collision && r_state != S_FAULT) begin
      w_state_nxt = S_FAULT;
    end else begin
      case (r_state)
        S_IDLE: w_go_run = w_accept && !w_new_stop;
        S_RUN: begin
          if (w_accept) begin
            w_go_dead  = w_new_stop || w_reverse;
            w_set_pend = !w_new_stop && w_reverse;
            w_go_run   = !w_new_stop && !w_reverse;
          end else if (r_cont) begin
`ifdef DRIVE_SEQ_WATCHDOG_EN
            w_go_dead = w_tick_end && (r_wd == WW'(1));
`endif
          end else begin
            w_go_dead = w_cnt_done;
          end
        end
        S_DEAD: begin
          if (w_cnt_done) begin
            if (r_pend_valid) begin
              w_go_run    = 1'b1;
              w_run_op    = r_pend_op;
              w_run_ticks = r_pend_ticks;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: w_go_dead = clearFault && !collision;
      endcase
      if (w_go_run)  w_state_nxt = S_RUN;
      if (w_go_dead) w_state_nxt = S_DEAD;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_cont       <= 1'b0;
      r_ticks      <= '0;
      r_presc      <= '0;
      r_pend_valid <= 1'b0;
      r_pend_op    <= '0;
      r_pend_ticks <= '0;
      r_last_a     <= DIR_NONE;
      r_last_b     <= DIR_NONE;
      r_en_a       <= 1'b0;
      r_en_b       <= 1'b0;
`ifdef DRIVE_SEQ_WATCHDOG_EN
      r_wd         <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      // NOTE: non-blocking assignments; a later assignment to the same register in this block wins.
      if (r_state == S_RUN || r_state == S_DEAD) begin
        r_presc <= w_tick_end ? '0 : r_presc + 1'b1;
        if (w_tick_end && r_ticks != 12'd0) r_ticks <= r_ticks - 1'b1;
`ifdef DRIVE_SEQ_WATCHDOG_EN
        if (w_tick_end && r_wd != '0) r_wd <= r_wd - 1'b1;
`endif
      end else begin
        r_presc <= '0;
      end
      if (r_state == S_DEAD && w_cnt_done) begin
        r_last_a <= DIR_NONE;
        r_last_b <= DIR_NONE;
      end
      if (w_go_dead) begin
        r_presc      <= '0;
        r_ticks      <= DEAD_LOAD;
        r_pend_valid <= w_set_pend;
        r_pend_op    <= cmdOp;
        r_pend_ticks <= cmdTicks;
      end
      if (w_go_run) begin
        r_presc      <= '0;
        r_op         <= w_run_op;
        r_ticks      <= w_run_ticks;
        r_cont       <= (w_run_ticks == 12'd0);
        r_last_a     <= w_run_a;
        r_last_b     <= w_run_b;
        r_pend_valid <= 1'b0;
`ifdef DRIVE_SEQ_WATCHDOG_EN
        r_wd         <= WD_LOAD;
`endif
      end
      if (w_state_nxt == S_FAULT) r_pend_valid <= 1'b0;
      // Enables follow the side that was driving and drop the moment RUN is left.
      r_en_a <= w_driving && (w_state_nxt == S_RUN) && (w_cur_a != DIR_NONE) &&
                ((r_op == OP_VEER_L) ? pwmVeer : pwmFull);
      r_en_b <= w_driving && (w_state_nxt == S_RUN) && (w_cur_b != DIR_NONE) &&
                ((r_op == OP_VEER_R) ? pwmVeer : pwmFull);
    end
  end

  assign w_driving = (r_state == S_RUN);
  assign {hbIn1, hbIn2} = w_driving ? w_cur_a : 2'b00;
  assign {hbIn3, hbIn4} = w_driving ? {w_cur_b[0], w_cur_b[1]} : 2'b00;
  assign hbEnA = r_en_a;
  assign hbEnB = r_en_b;
  assign busy  = (r_state != S_IDLE);
  assign fault = (r_state == S_FAULT);

endmodule

// File: tb/tb_drive_sequencer.sv
// Self-checking bench for drive_sequencer: cycle-count reference model plus directed literal checks.
module tb_drive_sequencer;
  localparam int CLK_HZ    = 1000;
  localparam int TICK_HZ   = 100;
  localparam int DEAD_T    = 2;
  localparam int WD_T      = 5;
  localparam int TICK_CYC  = CLK_HZ / TICK_HZ;

  logic        clock = 1'b0;
  logic        resetN, cmdValid, collision, clearFault, pwmFull, pwmVeer;
  logic [2:0]  cmdOp;
  logic [11:0] cmdTicks;
  logic        cmdReady, hbEnA, hbEnB, hbIn1, hbIn2, hbIn3, hbIn4, busy, fault;
  logic [3:0]  hb_in;

  int n_vec = 0;
  int n_err = 0;
  bit done  = 1'b0;
  int pwm_cnt = 0;

  drive_sequencer #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEAD_TIME_TICKS(DEAD_T), .WATCHDOG_TICKS(WD_T)
  ) dut (
    .clock(clock), .resetN(resetN), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdOp(cmdOp), .cmdTicks(cmdTicks), .collision(collision), .clearFault(clearFault),
    .pwmFull(pwmFull), .pwmVeer(pwmVeer), .hbEnA(hbEnA), .hbEnB(hbEnB),
    .hbIn1(hbIn1), .hbIn2(hbIn2), .hbIn3(hbIn3), .hbIn4(hbIn4),
    .busy(busy), .fault(fault)
  );

  assign hb_in = {hbIn1, hbIn2, hbIn3, hbIn4};

  always #5 clock = ~clock;

  // Per-opcode behaviour straight from the opcode map: +1 forward, -1 reverse, 0 none.
  int dir_a_tab  [8] = '{0, 1, -1, 1, 1, -1,  1, 0};
  int dir_b_tab  [8] = '{0, 1, -1, 1, 1,  1, -1, 0};
  bit veer_a_tab [8] = '{0, 0,  0, 1, 0,  0,  0, 0};
  bit veer_b_tab [8] = '{0, 0,  0, 0, 1,  0,  0, 0};

  typedef enum int {M_IDLE, M_RUN, M_DEAD, M_FAULT} mstate_e;
  mstate_e     m_state = M_IDLE;
  logic [2:0]  m_op = '0, m_pend_op = '0;
  logic [11:0] m_pend_ticks = '0;
  bit          m_cont = 1'b0, m_pend = 1'b0, e_en_a = 1'b0, e_en_b = 1'b0;
  int          m_left = 0, m_wd = 0, m_last_a = 0, m_last_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] pins(input int a, input int b);
    logic [1:0] pa, pb;
    pa = (a > 0) ? 2'b01 : (a < 0) ? 2'b10 : 2'b00;
    pb = (b > 0) ? 2'b10 : (b < 0) ? 2'b01 : 2'b00;
    return {pa, pb};
  endfunction

  task automatic start_run(input logic [2:0] op, input logic [11:0] t);
    m_state  = M_RUN;
    m_op     = op;
    m_cont   = (t == 0);
    m_left   = int'(t) * TICK_CYC;
    m_wd     = WD_T * TICK_CYC;
    m_last_a = dir_a_tab[op];
    m_last_b = dir_b_tab[op];
  endtask

  task automatic enter_dead();
    m_state = M_DEAD;
    m_left  = DEAD_T * TICK_CYC;
  endtask

  // Advances the reference model by one rising edge, in whole cycles rather than ticks.
  task automatic model_step();
    bit was_run, ready, acc;
    logic [2:0] old_op;
    was_run = (m_state == M_RUN);
    old_op  = m_op;
    if (!resetN) begin
      m_state = M_IDLE; m_op = '0; m_cont = 0; m_left = 0; m_wd = 0;
      m_pend = 0; m_last_a = 0; m_last_b = 0;
    end else begin
      ready = (m_state == M_IDLE) || (m_state == M_RUN && m_cont);
      acc   = cmdValid && ready;
      if (collision && m_state != M_FAULT) begin
        m_state = M_FAULT;
        m_pend  = 0;
      end else begin
        case (m_state)
          M_IDLE: if (acc && dir_a_tab[cmdOp] != 0) start_run(cmdOp, cmdTicks);
          M_RUN: begin
            if (acc) begin
              if (dir_a_tab[cmdOp] == 0) enter_dead();
              else if (dir_a_tab[cmdOp] * m_last_a < 0 || dir_b_tab[cmdOp] * m_last_b < 0) begin
                m_pend = 1; m_pend_op = cmdOp; m_pend_ticks = cmdTicks;
                enter_dead();
              end else start_run(cmdOp, cmdTicks);
            end else if (!m_cont) begin
              m_left--;
              if (m_left == 0) enter_dead();
            end else begin
`ifdef DRIVE_SEQ_WATCHDOG_EN
              m_wd--;
              if (m_wd == 0) enter_dead();
`endif
            end
          end
          M_DEAD: begin
            m_left--;
            if (m_left == 0) begin
              m_last_a = 0; m_last_b = 0;
              if (m_pend) begin
                m_pend = 0;
                start_run(m_pend_op, m_pend_ticks);
              end else m_state = M_IDLE;
            end
          end
          default: if (clearFault && !collision) enter_dead();
        endcase
      end
    end
    e_en_a = resetN && was_run && (m_state == M_RUN) && (veer_a_tab[old_op] ? pwmVeer : pwmFull);
    e_en_b = resetN && was_run && (m_state == M_RUN) && (veer_b_tab[old_op] ? pwmVeer : pwmFull);
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(posedge clock);
    #3;
    if (!done) begin
      check("cyc_hbIn", hb_in, (m_state == M_RUN) ? pins(dir_a_tab[m_op], dir_b_tab[m_op]) : 4'b0000);
      check("cyc_hbEn", {hbEnA, hbEnB}, {e_en_a, e_en_b});
      check("cyc_ready", cmdReady, (m_state == M_IDLE) || (m_state == M_RUN && m_cont));
      check("cyc_busy", busy, m_state != M_IDLE);
      check("cyc_fault", fault, m_state == M_FAULT);
    end
  end

  initial begin
    pwmFull = 1'b0;
    pwmVeer = 1'b0;
    forever begin
      @(negedge clock);
      pwm_cnt++;
      pwmFull = (pwm_cnt % 3) != 0;
      pwmVeer = (pwm_cnt % 5) == 0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input logic [2:0] op, input logic [11:0] t);
    cmdValid = 1'b1; cmdOp = op; cmdTicks = t;
    @(negedge clock);
    cmdValid = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; cmdValid = 1'b0; cmdOp = '0; cmdTicks = '0;
    collision = 1'b0; clearFault = 1'b0;
    cycles(3);
    check("rst_hbIn", hb_in, 4'b0000);
    check("rst_hbEn", {hbEnA, hbEnB}, 2'b00);
    check("rst_ready", cmdReady, 1);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    resetN = 1'b1;
    cycles(1);

    // Timed FWD for 3 ticks, then dead-time, then idle.
    send(3'd1, 12'd3);
    check("fwd_pins", hb_in, 4'b0110);
    check("fwd_ready", cmdReady, 0);
    cycles(29); check("fwd_last_run", hb_in, 4'b0110);
    cycles(1);  check("fwd_dead_pins", hb_in, 4'b0000); check("fwd_dead_busy", busy, 1);
    cycles(19); check("fwd_dead_last", busy, 1);
    cycles(1);  check("fwd_idle_busy", busy, 0); check("fwd_idle_ready", cmdReady, 1);

    // Continuous VEER_L, then FWD with no dead-time.
    send(3'd3, 12'd0);
    check("veer_pins", hb_in, 4'b0110); check("veer_ready", cmdReady, 1);
    cycles(10);
    send(3'd1, 12'd0);
    check("veer_fwd_busy", busy, 1); check("veer_fwd_pins", hb_in, 4'b0110);
    cycles(5);

    // Reversal: dead-time with the REV held pending, then timed REV.
    send(3'd2, 12'd2);
    check("rev_dead_pins", hb_in, 4'b0000); check("rev_dead_ready", cmdReady, 0);
    cycles(19); check("rev_dead_last", hb_in, 4'b0000); check("rev_dead_ready2", cmdReady, 0);
    cycles(1);  check("rev_pins", hb_in, 4'b1001);
    cycles(40); check("rev_done_busy", busy, 0);

    // Collision during timed PIVOT_R, clear attempts, release.
    send(3'd6, 12'd10);
    check("pivr_pins", hb_in, 4'b0101);
    cycles(5);
    collision = 1'b1; cycles(1);
    check("col_pins", hb_in, 4'b0000); check("col_en", {hbEnA, hbEnB}, 2'b00); check("col_fault", fault, 1);
    clearFault = 1'b1; cycles(2); check("col_hold_fault", fault, 1);
    collision = 1'b0; clearFault = 1'b0; cycles(3); check("col_latched", fault, 1);
    clearFault = 1'b1; cycles(1); clearFault = 1'b0;
    check("clr_fault", fault, 0); check("clr_busy", busy, 1); check("clr_pins", hb_in, 4'b0000);
    cycles(19); check("clr_dead_last", busy, 1);
    cycles(1);  check("clr_idle", busy, 0); check("clr_ready", cmdReady, 1);

    // Collision wins over a same-cycle accept in IDLE.
    collision = 1'b1; cmdValid = 1'b1; cmdOp = 3'd1; cmdTicks = 12'd0;
    cycles(1); cmdValid = 1'b0; collision = 1'b0;
    check("colacc_fault", fault, 1); check("colacc_pins", hb_in, 4'b0000);
    clearFault = 1'b1; cycles(1); clearFault = 1'b0;
    cycles(20); check("colacc_idle", busy, 0);

    // A pending reversal is dropped by a fault.
    send(3'd1, 12'd0); cycles(3);
    send(3'd2, 12'd0);
    cycles(5); collision = 1'b1; cycles(1); collision = 1'b0;
    check("pend_fault", fault, 1);
    clearFault = 1'b1; cycles(1); clearFault = 1'b0;
    cycles(20);
    check("pend_discard_busy", busy, 0); check("pend_discard_pins", hb_in, 4'b0000);

    // Reserved opcode behaves as STOP in IDLE.
    send(3'd7, 12'd5);
    check("op7_busy", busy, 0); check("op7_pins", hb_in, 4'b0000); check("op7_ready", cmdReady, 1);

    // Reset mid-run, then a one-tick run proves the prescaler restarted.
    send(3'd4, 12'd0);
    check("veerr_pins", hb_in, 4'b0110);
    cycles(7);
    resetN = 1'b0; cycles(1);
    check("mid_rst_busy", busy, 0); check("mid_rst_pins", hb_in, 4'b0000);
    check("mid_rst_en", {hbEnA, hbEnB}, 2'b00); check("mid_rst_ready", cmdReady, 1);
    resetN = 1'b1; cycles(3);
    send(3'd1, 12'd1);
    cycles(9); check("one_tick_run", hb_in, 4'b0110);
    cycles(1); check("one_tick_dead", hb_in, 4'b0000);
    cycles(20); check("one_tick_idle", busy, 0);

    // Continuous FWD with no further commands.
    send(3'd1, 12'd0);
`ifdef DRIVE_SEQ_WATCHDOG_EN
    cycles(49); check("wd_run", hb_in, 4'b0110);
    cycles(1);  check("wd_dead_pins", hb_in, 4'b0000); check("wd_dead_busy", busy, 1);
    cycles(20); check("wd_idle", busy, 0);
`else
    cycles(500); check("nowd_run_pins", hb_in, 4'b0110); check("nowd_run_busy", busy, 1);
    send(3'd0, 12'd0);
    check("stop_dead_pins", hb_in, 4'b0000); check("stop_dead_busy", busy, 1);
    cycles(20); check("stop_idle", busy, 0);
`endif

    cycles(2);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
